cordic_axil_slave: RTL and testbench
====================================

Name: cordic_axil_slave

Overview:
AXI4-Lite responder for the cordic IP: the register-file end of the S00_AXI interface that the master VIP drives. Terminates AW/W/B/AR/R handshakes, holds the CORDIC operand/control registers, issues a one-cycle start to the CORDIC core, and captures its results and status for readback. Sits between the AXI interconnect and the CORDIC datapath inside the cordic_v1_0 wrapper.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data bus width (only 32 supported)
C_S_AXI_ADDR_WIDTH, 5, byte address width (8 word registers)

Ports:
S_AXI_ACLK  in  1  single clock
S_AXI_ARESETN  in  1  asynchronous active-low reset
S_AXI_AWADDR/AWPROT/AWVALID  in  5/3/1  write address channel (AWPROT ignored)
S_AXI_AWREADY  out  1  write address ready
S_AXI_WDATA/WSTRB/WVALID  in  32/4/1  write data channel
S_AXI_WREADY  out  1  write data ready
S_AXI_BRESP/BVALID  out  2/1  write response
S_AXI_BREADY  in  1  response accept
S_AXI_ARADDR/ARPROT/ARVALID  in  5/3/1  read address channel (ARPROT ignored)
S_AXI_ARREADY  out  1  read address ready
S_AXI_RDATA/RRESP/RVALID  out  32/2/1  read data channel
S_AXI_RREADY  in  1  read data accept
core_start  out  1  one-cycle start pulse to CORDIC core
core_mode  out  2  CTRL[2:1]
core_x_in/core_y_in/core_z_in  out  32  operand registers
core_x_out/core_y_out  in  32  core results
core_done  in  1  one-cycle completion pulse from core

Behaviour:
- Register map (word index = addr[4:2], addr[1:0] ignored): 0x00 CTRL RW; 0x04 X_IN RW; 0x08 Y_IN RW; 0x0C Z_IN RW; 0x10 X_OUT RO; 0x14 Y_OUT RO; 0x18 STATUS RO {29'b0, OVERRUN, DONE, BUSY}; 0x1C reserved, reads 0.
- RW registers store full written value (byte-masked by WSTRB) and read back exactly; plain storage, no self-clear.
- Reset: all registers, captured results, STATUS 0; AWREADY/WREADY/ARREADY=0 for the reset cycle, then 1; BVALID/RVALID=0; BRESP/RRESP=00; RDATA=0; core_start=0. Reset mid-transaction abandons any pending handshake; no response is issued.
- Write path: AW and W accepted independently into one-entry holding registers; AWREADY low while address held, WREADY low while data held. Write commits on the cycle both are held and BVALID is low; BVALID rises the next cycle, holding buffers clear. BVALID held until BREADY; no new commit while BVALID high. AW and W in the same cycle: BVALID two cycles after handshake at latest.
- BRESP: OKAY for 0x00-0x0C; SLVERR (2'b10) for 0x10-0x1C, no state change.
- Start: committed CTRL write with WSTRB[0]=1 and WDATA[0]=1 -> core_start high exactly one cycle after commit. If BUSY=1 at that point: no pulse, OVERRUN set.
- BUSY set with core_start, cleared on core_done. core_done loads X_OUT/Y_OUT from core inputs and sets DONE. core_done and new start same cycle: results captured, DONE set, BUSY stays 1.
- Read path: ARREADY high when RVALID low; RVALID and RDATA registered one cycle after AR handshake, held stable until RREADY. RRESP always OKAY.
- STATUS read clears DONE and OVERRUN on the AR handshake; returned data is the pre-clear value. core_done coinciding with the clearing read: DONE ends 1.
- Read and write to the same register committed in the same cycle: read returns old value.

Decomposition:
- Package cordic_axil_pkg: register offset constants, STATUS bit indices, AXI response codes (OKAY, SLVERR).
- One sub-module natural: cordic_axil_wr_chan (AW/W holding registers, commit strobe, B channel); read path and register file stay in top.

Test Plan:
- Reset release, write 0x1,0x2,0x3,0x4 to 0x00/04/08/0C, read back -> 0x1,0x2,0x3,0x4, BRESP/RRESP OKAY; core_start pulses once after CTRL write.
- W presented 3 cycles before AW (X_IN=0xDEADBEEF) -> single commit after AW, BVALID one cycle later, readback 0xDEADBEEF.
- Write WSTRB=4'b0010 data 0xAABBCCDD to Y_IN holding 0x11223344 -> readback 0x1122CC44.
- Start, core_done with x_out=0x100,y_out=0x200 -> X_OUT=0x100, Y_OUT=0x200, STATUS=0x2 then 0x0 on second read.
- Start while BUSY -> no core_start, STATUS reads 0x5 (OVERRUN|BUSY); write 0x10 -> BRESP SLVERR, X_OUT unchanged.
- BREADY/RREADY held low 5 cycles -> BVALID/RVALID and RDATA stable, AWREADY/ARREADY stay low until accepted.

Source files
------------

// File: rtl/cordic_axil_pkg.sv
// Shared constants, write-command payload and byte-strobe helper for the CORDIC AXI4-Lite register file.
package cordic_axil_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned IDX_W  = 3;

    localparam logic [IDX_W-1:0] REG_CTRL   = 3'd0;
    localparam logic [IDX_W-1:0] REG_X_IN   = 3'd1;
    localparam logic [IDX_W-1:0] REG_Y_IN   = 3'd2;
    localparam logic [IDX_W-1:0] REG_Z_IN   = 3'd3;
    localparam logic [IDX_W-1:0] REG_X_OUT  = 3'd4;
    localparam logic [IDX_W-1:0] REG_Y_OUT  = 3'd5;
    localparam logic [IDX_W-1:0] REG_STATUS = 3'd6;

    localparam int unsigned STAT_BUSY    = 0;
    localparam int unsigned STAT_DONE    = 1;
    localparam int unsigned STAT_OVERRUN = 2;
    localparam int unsigned CTRL_START   = 0;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef struct packed {
        logic [IDX_W-1:0]  idx;
        logic [DATA_W-1:0] data;
        logic [STRB_W-1:0] strb;
    } wr_cmd_t;

    function automatic logic [DATA_W-1:0] apply_strb(input logic [DATA_W-1:0] old_v,
                                                     input logic [DATA_W-1:0] new_v,
                                                     input logic [STRB_W-1:0] strb);
        logic [DATA_W-1:0] res;
        res = old_v;
        for (int unsigned b = 0; b < STRB_W; b++) begin
            if (strb[b]) res[b*8 +: 8] = new_v[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/cordic_axil_wr_chan.sv
// AXI4-Lite write side: independent AW/W holding registers, commit strobe and B channel.
module cordic_axil_wr_chan
    import cordic_axil_pkg::*;
#(
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic              awvalid,
    output logic              awready,
    input  logic [DATA_W-1:0] wdata,
    input  logic [STRB_W-1:0] wstrb,
    input  logic              wvalid,
    output logic              wready,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready,
    output logic              commit_c,
    output wr_cmd_t           cmd_c
);

    logic              aw_held_q, aw_held_d;
    logic [IDX_W-1:0]  aw_idx_q, aw_idx_d;
    logic              w_held_q, w_held_d;
    logic [DATA_W-1:0] w_data_q, w_data_d;
    logic [STRB_W-1:0] w_strb_q, w_strb_d;
    logic              bvalid_q, bvalid_d;
    logic [1:0]        bresp_q, bresp_d;
    logic              awready_q, awready_d;
    logic              wready_q, wready_d;

    logic unused_addr_bits;
    assign unused_addr_bits = ^awaddr[ADDR_W-IDX_W-1:0];

    // A commit drains both holding registers; ready stays low while anything is held or B is pending.
    always_comb begin
        aw_held_d = aw_held_q;
        aw_idx_d  = aw_idx_q;
        w_held_d  = w_held_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        commit_c  = aw_held_q & w_held_q & ~bvalid_q;

        if (commit_c) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = (aw_idx_q >= REG_X_OUT) ? RESP_SLVERR : RESP_OKAY;
        end else if (bvalid_q && bready) begin
            bvalid_d = 1'b0;
        end

        if (awvalid && awready_q) begin
            aw_held_d = 1'b1;
            aw_idx_d  = awaddr[ADDR_W-1 -: IDX_W];
        end
        if (wvalid && wready_q) begin
            w_held_d = 1'b1;
            w_data_d = wdata;
            w_strb_d = wstrb;
        end

        awready_d = ~aw_held_d & ~bvalid_d;
        wready_d  = ~w_held_d & ~bvalid_d;
        cmd_c     = '{idx: aw_idx_q, data: w_data_q, strb: w_strb_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_held_q <= 1'b0;
            aw_idx_q  <= '0;
            w_held_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
        end else begin
            aw_held_q <= aw_held_d;
            aw_idx_q  <= aw_idx_d;
            w_held_q  <= w_held_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
        end
    end

    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;

endmodule

// File: rtl/cordic_axil_slave.sv
// AXI4-Lite register file for the CORDIC core: operands, start pulse, captured results and status.
module cordic_axil_slave
    import cordic_axil_pkg::*;
#(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic                              core_start,
    output logic [1:0]                        core_mode,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     core_x_in,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     core_y_in,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     core_z_in,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     core_x_out,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     core_y_out,
    input  logic                              core_done
);

    logic    commit;
    wr_cmd_t cmd;

    cordic_axil_wr_chan #(
        .ADDR_W (C_S_AXI_ADDR_WIDTH)
    ) u_wr_chan (
        .clk      (S_AXI_ACLK),
        .rst_n    (S_AXI_ARESETN),
        .awaddr   (S_AXI_AWADDR),
        .awvalid  (S_AXI_AWVALID),
        .awready  (S_AXI_AWREADY),
        .wdata    (S_AXI_WDATA),
        .wstrb    (S_AXI_WSTRB),
        .wvalid   (S_AXI_WVALID),
        .wready   (S_AXI_WREADY),
        .bresp    (S_AXI_BRESP),
        .bvalid   (S_AXI_BVALID),
        .bready   (S_AXI_BREADY),
        .commit_c (commit),
        .cmd_c    (cmd)
    );

    logic [DATA_W-1:0] ctrl_q, ctrl_d;
    logic [DATA_W-1:0] x_in_q, x_in_d;
    logic [DATA_W-1:0] y_in_q, y_in_d;
    logic [DATA_W-1:0] z_in_q, z_in_d;
    logic [DATA_W-1:0] x_out_q, x_out_d;
    logic [DATA_W-1:0] y_out_q, y_out_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              overrun_q, overrun_d;
    logic              core_start_q, core_start_d;
    logic              arready_q, arready_d;
    logic              rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              ar_hs;
    logic [IDX_W-1:0]  ar_idx;
    logic              status_rd;
    logic              start_req;
    logic [DATA_W-1:0] status_word;

    logic unused_bits;
    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                           S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-IDX_W-1:0]};

    // Register file writes, start/overrun decision and status bookkeeping.
    always_comb begin
        ctrl_d    = ctrl_q;
        x_in_d    = x_in_q;
        y_in_d    = y_in_q;
        z_in_d    = z_in_q;
        x_out_d   = x_out_q;
        y_out_d   = y_out_q;
        busy_d    = busy_q;
        done_d    = done_q;
        overrun_d = overrun_q;

        ar_hs     = S_AXI_ARVALID & arready_q;
        ar_idx    = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1 -: IDX_W];
        status_rd = ar_hs && (ar_idx == REG_STATUS);

        if (commit) begin
            case (cmd.idx)
                REG_CTRL: ctrl_d = apply_strb(ctrl_q, cmd.data, cmd.strb);
                REG_X_IN: x_in_d = apply_strb(x_in_q, cmd.data, cmd.strb);
                REG_Y_IN: y_in_d = apply_strb(y_in_q, cmd.data, cmd.strb);
                REG_Z_IN: z_in_d = apply_strb(z_in_q, cmd.data, cmd.strb);
                default:  ;
            endcase
        end

        start_req    = commit && (cmd.idx == REG_CTRL) && cmd.strb[0] && cmd.data[CTRL_START];
        core_start_d = start_req & ~busy_q;

        // Clear-on-read loses to a set arriving in the same cycle.
        if (status_rd) begin
            done_d    = 1'b0;
            overrun_d = 1'b0;
        end
        if (start_req && busy_q) overrun_d = 1'b1;
        if (core_done) begin
            x_out_d = core_x_out;
            y_out_d = core_y_out;
            done_d  = 1'b1;
            busy_d  = 1'b0;
        end
        if (core_start_d) busy_d = 1'b1;
    end

    // Read channel: data is sampled from current register state at the AR handshake.
    always_comb begin
        status_word               = '0;
        status_word[STAT_BUSY]    = busy_q;
        status_word[STAT_DONE]    = done_q;
        status_word[STAT_OVERRUN] = overrun_q;

        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        if (ar_hs) begin
            rvalid_d = 1'b1;
            case (ar_idx)
                REG_CTRL:   rdata_d = ctrl_q;
                REG_X_IN:   rdata_d = x_in_q;
                REG_Y_IN:   rdata_d = y_in_q;
                REG_Z_IN:   rdata_d = z_in_q;
                REG_X_OUT:  rdata_d = x_out_q;
                REG_Y_OUT:  rdata_d = y_out_q;
                REG_STATUS: rdata_d = status_word;
                default:    rdata_d = '0;
            endcase
        end else if (rvalid_q && S_AXI_RREADY) begin
            rvalid_d = 1'b0;
        end
        arready_d = ~rvalid_d;
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            ctrl_q       <= '0;
            x_in_q       <= '0;
            y_in_q       <= '0;
            z_in_q       <= '0;
            x_out_q      <= '0;
            y_out_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            overrun_q    <= 1'b0;
            core_start_q <= 1'b0;
            arready_q    <= 1'b0;
            rvalid_q     <= 1'b0;
            rdata_q      <= '0;
        end else begin
            ctrl_q       <= ctrl_d;
            x_in_q       <= x_in_d;
            y_in_q       <= y_in_d;
            z_in_q       <= z_in_d;
            x_out_q      <= x_out_d;
            y_out_q      <= y_out_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            overrun_q    <= overrun_d;
            core_start_q <= core_start_d;
            arready_q    <= arready_d;
            rvalid_q     <= rvalid_d;
            rdata_q      <= rdata_d;
        end
    end

    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = RESP_OKAY;
    assign core_start    = core_start_q;
    assign core_mode     = ctrl_q[2:1];
    assign core_x_in     = x_in_q;
    assign core_y_in     = y_in_q;
    assign core_z_in     = z_in_q;

endmodule

// File: tb/tb_cordic_axil_slave.sv
// Scoreboard bench for cordic_axil_slave: queued expected BRESP/RDATA checked as the DUT responds.
module tb_cordic_axil_slave;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  awaddr = '0;
    logic [2:0]  awprot = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [4:0]  araddr = '0;
    logic [2:0]  arprot = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic        core_start;
    logic [1:0]  core_mode;
    logic [31:0] core_x_in, core_y_in, core_z_in;
    logic [31:0] core_x_out = '0;
    logic [31:0] core_y_out = '0;
    logic        core_done = 1'b0;

    int errors = 0;
    int checks = 0;
    int start_cnt = 0;

    logic [1:0]  exp_bresp_q[$];
    logic [31:0] exp_rdata_q[$];
    logic [31:0] model_rw[4];

    always #5 clk = ~clk;

    cordic_axil_slave dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (awprot),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (arprot),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .core_start    (core_start),
        .core_mode     (core_mode),
        .core_x_in     (core_x_in),
        .core_y_in     (core_y_in),
        .core_z_in     (core_z_in),
        .core_x_out    (core_x_out),
        .core_y_out    (core_y_out),
        .core_done     (core_done)
    );

    always @(posedge clk) if (core_start) start_cnt++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic model_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb);
        logic [1:0] i;
        i = addr[3:2];
        for (int b = 0; b < 4; b++) if (strb[b]) model_rw[i][b*8 +: 8] = data[b*8 +: 8];
    endtask

    // Write with optional W-first lead and B back-pressure; reports start pulse seen with BVALID and B latency.
    task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int w_lead, input int hold, output logic start_seen, output int lat);
        int n;
        bit aw_done, w_done;
        logic aw_fire, w_fire;
        logic [1:0] exp;
        exp_bresp_q.push_back(addr >= 5'h10 ? 2'b10 : 2'b00);
        if (addr < 5'h10) model_write(addr, data, strb);
        aw_done = 0; w_done = 0; n = 0;
        wdata = data; wstrb = strb; wvalid = 1'b1;
        if (w_lead == 0) begin awaddr = addr; awvalid = 1'b1; end
        while (!(aw_done && w_done) && n < 50) begin
            aw_fire = awvalid & awready;
            w_fire  = wvalid & wready;
            cycle(); n++;
            if (aw_fire) begin awvalid = 1'b0; aw_done = 1; end
            if (w_fire)  begin wvalid = 1'b0; w_done = 1; end
            if (w_lead > 0 && w_done && !aw_done) begin
                checks++;
                if (wready !== 1'b0) begin errors++; $display("FAIL wready_held: got %b expected 0", wready); end
            end
            if (!aw_done && !awvalid && n >= w_lead) begin awaddr = addr; awvalid = 1'b1; end
        end
        checks++;
        if (!(aw_done && w_done)) begin
            errors++; $display("FAIL aw_w_handshake: timeout addr %h", addr);
            awvalid = 1'b0; wvalid = 1'b0;
        end
        lat = 0;
        while (!bvalid && lat < 20) begin cycle(); lat++; end
        start_seen = core_start;
        exp = exp_bresp_q.pop_front();
        for (int i = 0; i < hold; i++) begin
            checks++;
            if (bvalid !== 1'b1 || bresp !== exp || awready !== 1'b0 || wready !== 1'b0) begin
                errors++;
                $display("FAIL b_hold: bvalid=%b bresp=%b awready=%b wready=%b expected 1/%b/0/0",
                         bvalid, bresp, awready, wready, exp);
            end
            cycle();
        end
        bready = 1'b1;
        checks++;
        if (bvalid !== 1'b1 || bresp !== exp) begin
            errors++; $display("FAIL bresp addr %h: bvalid=%b bresp=%b expected 1/%b", addr, bvalid, bresp, exp);
        end
        cycle();
        bready = 1'b0;
        checks++;
        if (bvalid !== 1'b0) begin errors++; $display("FAIL bvalid_drop: got %b expected 0", bvalid); end
    endtask

    task automatic axi_read(input logic [4:0] addr, input logic [31:0] expv, input int hold);
        int n;
        logic [31:0] exp;
        exp_rdata_q.push_back(expv);
        araddr = addr; arvalid = 1'b1; n = 0;
        while (!arready && n < 50) begin cycle(); n++; end
        cycle();
        arvalid = 1'b0;
        checks++;
        if (rvalid !== 1'b1) begin errors++; $display("FAIL r_latency addr %h: rvalid=%b expected 1", addr, rvalid); end
        n = 0;
        while (!rvalid && n < 20) begin cycle(); n++; end
        exp = exp_rdata_q.pop_front();
        for (int i = 0; i < hold; i++) begin
            checks++;
            if (rvalid !== 1'b1 || rdata !== exp || arready !== 1'b0) begin
                errors++;
                $display("FAIL r_hold: rvalid=%b rdata=%h arready=%b expected 1/%h/0", rvalid, rdata, arready, exp);
            end
            cycle();
        end
        rready = 1'b1;
        checks++;
        if (rvalid !== 1'b1 || rdata !== exp || rresp !== 2'b00) begin
            errors++;
            $display("FAIL rdata addr %h: rvalid=%b rdata=%h rresp=%b expected 1/%h/00", addr, rvalid, rdata, rresp, exp);
        end
        cycle();
        rready = 1'b0;
    endtask

    task automatic pulse_done(input logic [31:0] x, input logic [31:0] y);
        core_x_out = x; core_y_out = y; core_done = 1'b1;
        cycle();
        core_done = 1'b0;
    endtask

    task automatic check_start(input string name, input logic got, input logic exp, input int lat);
        checks++;
        if (got !== exp || lat != 1) begin
            errors++; $display("FAIL %s: start=%b lat=%0d expected start=%b lat=1", name, got, lat, exp);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) model_rw[i] = '0;
        rst_n = 1'b0;
        repeat (3) cycle();
        checks++;
        if (awready !== 0 || wready !== 0 || arready !== 0 || bvalid !== 0 || rvalid !== 0 ||
            rdata !== 0 || bresp !== 0 || core_start !== 0 || core_x_in !== 0) begin
            errors++; $display("FAIL reset_outputs: aw=%b w=%b ar=%b b=%b r=%b rdata=%h start=%b",
                               awready, wready, arready, bvalid, rvalid, rdata, core_start);
        end
        rst_n = 1'b1;
        checks++;
        if (awready !== 0 || arready !== 0) begin
            errors++; $display("FAIL reset_cycle_ready: aw=%b ar=%b expected 0/0", awready, arready);
        end
        cycle();
        checks++;
        if (awready !== 1 || wready !== 1 || arready !== 1) begin
            errors++; $display("FAIL post_reset_ready: aw=%b w=%b ar=%b expected 1/1/1", awready, wready, arready);
        end
    endtask

    task automatic test_basic_rw();
        logic ss; int lat;
        axi_write(5'h00, 32'h1, 4'hF, 0, 0, ss, lat); check_start("ctrl_start", ss, 1'b1, lat);
        axi_write(5'h04, 32'h2, 4'hF, 0, 0, ss, lat); check_start("x_in_nostart", ss, 1'b0, lat);
        axi_write(5'h08, 32'h3, 4'hF, 0, 0, ss, lat); check_start("y_in_nostart", ss, 1'b0, lat);
        axi_write(5'h0C, 32'h4, 4'hF, 0, 0, ss, lat); check_start("z_in_nostart", ss, 1'b0, lat);
        for (int i = 0; i < 4; i++) axi_read(5'(i * 4), model_rw[i], 0);
        checks++;
        if (core_x_in !== 32'h2 || core_y_in !== 32'h3 || core_z_in !== 32'h4 || core_mode !== 2'b00 || start_cnt != 1) begin
            errors++; $display("FAIL core_operands: x=%h y=%h z=%h mode=%b starts=%0d expected 2/3/4/00/1",
                               core_x_in, core_y_in, core_z_in, core_mode, start_cnt);
        end
    endtask

    task automatic test_done();
        pulse_done(32'h100, 32'h200);
        axi_read(5'h10, 32'h100, 0);
        axi_read(5'h14, 32'h200, 0);
        axi_read(5'h18, 32'h2, 0);
        axi_read(5'h18, 32'h0, 0);
    endtask

    task automatic test_w_before_aw();
        logic ss; int lat;
        axi_write(5'h04, 32'hDEADBEEF, 4'hF, 3, 0, ss, lat);
        check_start("w_lead_latency", ss, 1'b0, lat);
        axi_read(5'h04, 32'hDEADBEEF, 0);
    endtask

    task automatic test_strobe();
        logic ss; int lat;
        axi_write(5'h08, 32'h11223344, 4'hF, 0, 0, ss, lat);
        axi_write(5'h08, 32'hAABBCCDD, 4'b0010, 0, 0, ss, lat);
        axi_read(5'h08, model_rw[2], 0);
        checks++;
        if (model_rw[2] !== 32'h1122CC44) begin
            errors++; $display("FAIL strobe_model: got %h expected 1122cc44", model_rw[2]);
        end
    endtask

    task automatic test_overrun();
        logic ss; int lat;
        axi_write(5'h00, 32'h1, 4'hF, 0, 0, ss, lat); check_start("start_idle", ss, 1'b1, lat);
        axi_write(5'h00, 32'h1, 4'hF, 0, 0, ss, lat); check_start("start_busy", ss, 1'b0, lat);
        checks++;
        if (start_cnt != 2) begin errors++; $display("FAIL start_count: got %0d expected 2", start_cnt); end
        axi_read(5'h18, 32'h5, 0);
        axi_read(5'h18, 32'h1, 0);
        axi_write(5'h10, 32'h12345678, 4'hF, 0, 0, ss, lat);
        axi_write(5'h1C, 32'h0000FFFF, 4'hF, 0, 0, ss, lat);
        axi_read(5'h10, 32'h100, 0);
        axi_read(5'h1C, 32'h0, 0);
        pulse_done(32'h300, 32'h400);
        axi_read(5'h18, 32'h2, 0);
        axi_read(5'h14, 32'h400, 0);
    endtask

    task automatic test_back_to_back();
        logic ss; int lat;
        axi_write(5'h0C, 32'h55AA55AA, 4'hF, 0, 5, ss, lat);
        axi_read(5'h0C, 32'h55AA55AA, 5);
        axi_write(5'h00, 32'h6, 4'hF, 0, 0, ss, lat); check_start("ctrl_mode_only", ss, 1'b0, lat);
        axi_read(5'h00, 32'h6, 0);
        checks++;
        if (core_mode !== 2'b11) begin errors++; $display("FAIL core_mode: got %b expected 11", core_mode); end
    endtask

    initial begin
        test_reset();
        test_basic_rw();
        test_done();
        test_w_before_aw();
        test_strobe();
        test_overrun();
        test_back_to_back();
        repeat (2) cycle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
